// File: rtl/input_port_conditioner.sv
// Pushbutton front end for the CPU input port: per-bit two-flop synchroniser,
// counter debounce, rising-edge capture into read-clear sticky bits, and a level/sticky mux.
module input_port_conditioner #(
   parameter int WIDTH    = 4,
   parameter int DB_COUNT = 50000,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_buttons,
   input  logic             rd_strobe,
   input  logic             mode_sticky,
   output logic [WIDTH-1:0] pins_out,
   output logic [WIDTH-1:0] stable_level,
   output logic             press_pending,
   output logic             event_overflow
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DB_COUNT - 1);

   logic [WIDTH-1:0]            sync1;
   logic [WIDTH-1:0]            sync2;
   logic [WIDTH-1:0]            sticky;
   logic [WIDTH-1:0]            accept;
   logic [WIDTH-1:0]            stable_next;
   logic [WIDTH-1:0]            rise;
   logic [WIDTH-1:0][CNT_W-1:0] counter;

   // A bit is accepted once its synchronised value has disagreed for the whole window.
   always_comb begin
      accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         accept[i] = (sync2[i] != stable_level[i]) && (counter[i] == LAST_COUNT);
      end
   end

   assign stable_next = stable_level ^ accept;
   assign rise        = stable_next & ~stable_level;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_buttons;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         counter      <= '0;
         stable_level <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if ((sync2[i] == stable_level[i]) || accept[i]) begin
               counter[i] <= '0;
            end else begin
               counter[i] <= counter[i] + CNT_W'(1);
            end
         end
         stable_level <= stable_next;
      end
   end

   // A new press on the same edge as a read survives the clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sticky         <= '0;
         event_overflow <= 1'b0;
      end else begin
         sticky <= rise | (sticky & ~{WIDTH{rd_strobe}});
         if (((rise & sticky) != '0) && !rd_strobe) begin
            event_overflow <= 1'b1;
         end else if (rd_strobe) begin
            event_overflow <= 1'b0;
         end
      end
   end

   assign pins_out      = mode_sticky ? sticky : stable_level;
   assign press_pending = |sticky;

endmodule

// File: tb/tb_input_port_conditioner.sv
// Bench for input_port_conditioner: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a sample-window model.
module tb_input_port_conditioner;

   localparam int WIDTH = 4;
   localparam int DB    = 4;
   localparam int CW    = 3;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] raw_buttons = '0;
   logic             rd_strobe = 1'b0;
   logic             mode_sticky = 1'b0;
   logic [WIDTH-1:0] pins_out;
   logic [WIDTH-1:0] stable_level;
   logic             press_pending;
   logic             event_overflow;

   int checks = 0;
   int errors = 0;

   input_port_conditioner #(.WIDTH(WIDTH), .DB_COUNT(DB), .CNT_W(CW)) dut (
      .clock         (clock),
      .reset         (reset),
      .raw_buttons   (raw_buttons),
      .rd_strobe     (rd_strobe),
      .mode_sticky   (mode_sticky),
      .pins_out      (pins_out),
      .stable_level  (stable_level),
      .press_pending (press_pending),
      .event_overflow(event_overflow)
   );

   always #5 clock = ~clock;

   // Model: a level is accepted when the DB raw samples that have reached the end
   // of the two-stage synchroniser all disagree with the current stable level.
   logic [WIDTH-1:0] m_stable = '0;
   logic [WIDTH-1:0] m_sticky = '0;
   logic             m_ov = 1'b0;
   logic [WIDTH-1:0] hist [0:DB];
   logic [WIDTH-1:0] m_next;
   logic [WIDTH-1:0] m_rise;
   bit               all_diff;

   initial begin
      for (int k = 0; k <= DB; k++) hist[k] = '0;
   end

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_stable = '0;
         m_sticky = '0;
         m_ov     = 1'b0;
         for (int k = 0; k <= DB; k++) hist[k] = '0;
      end else begin
         m_next = m_stable;
         for (int b = 0; b < WIDTH; b++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= DB; k++) begin
               if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
            end
            if (all_diff) m_next[b] = ~m_stable[b];
         end
         m_rise = m_next & ~m_stable;
         if (((m_rise & m_sticky) != '0) && !rd_strobe) m_ov = 1'b1;
         else if (rd_strobe) m_ov = 1'b0;
         m_sticky = m_rise | (rd_strobe ? '0 : m_sticky);
         m_stable = m_next;
         for (int k = DB; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = raw_buttons;
      end
   end

   task automatic check_output(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      check_output("pins_out", pins_out, mode_sticky ? m_sticky : m_stable);
      check_output("stable_level", stable_level, m_stable);
      check_output("press_pending", {3'b0, press_pending}, {3'b0, |m_sticky});
      check_output("event_overflow", {3'b0, event_overflow}, {3'b0, m_ov});
   end

   // Every directed action happens 2 time units after a rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic apply_stimulus(input logic [WIDTH-1:0] raw, input logic rd, input logic mode);
      raw_buttons = raw;
      rd_strobe   = rd;
      mode_sticky = mode;
   endtask

   task automatic read_port();
      rd_strobe = 1'b1;
      step(1);
      rd_strobe = 1'b0;
   endtask

   initial begin
      #1 reset = 1'b0;
      apply_stimulus(4'b1111, 1'b0, 1'b0);
      step(3);
      check_output("lit_reset_pins", pins_out, 4'b0000);
      check_output("lit_reset_stable", stable_level, 4'b0000);
      reset = 1'b1;
      step(5);
      check_output("lit_release_edge5", stable_level, 4'b0000);
      step(1);
      check_output("lit_release_edge6", stable_level, 4'b1111);
      check_output("lit_release_pending", {3'b0, press_pending}, 4'b0001);

      apply_stimulus(4'b0000, 1'b0, 1'b0);
      step(8);
      read_port();
      check_output("lit_cleared_pending", {3'b0, press_pending}, 4'b0000);

      // glitch of three cycles on bit 0
      apply_stimulus(4'b0001, 1'b0, 1'b0);
      step(3);
      apply_stimulus(4'b0000, 1'b0, 1'b0);
      step(8);
      check_output("lit_glitch_stable", stable_level, 4'b0000);
      check_output("lit_glitch_pending", {3'b0, press_pending}, 4'b0000);

      // sticky read-clear
      apply_stimulus(4'b0100, 1'b0, 1'b1);
      step(10);
      apply_stimulus(4'b0000, 1'b0, 1'b1);
      step(8);
      check_output("lit_sticky_held", pins_out, 4'b0100);
      rd_strobe = 1'b1;
      #1 check_output("lit_sticky_strobe", pins_out, 4'b0100);
      step(1);
      rd_strobe = 1'b0;
      check_output("lit_sticky_after", pins_out, 4'b0000);
      check_output("lit_sticky_pending", {3'b0, press_pending}, 4'b0000);

      // set/clear collision
      apply_stimulus(4'b0001, 1'b0, 1'b1);
      step(8);
      apply_stimulus(4'b0000, 1'b0, 1'b1);
      step(8);
      check_output("lit_collide_pre", pins_out, 4'b0001);
      apply_stimulus(4'b0010, 1'b0, 1'b1);
      step(5);
      check_output("lit_collide_edge5", stable_level, 4'b0000);
      read_port();
      check_output("lit_collide_sticky", pins_out, 4'b0010);
      apply_stimulus(4'b0000, 1'b0, 1'b1);
      step(8);
      read_port();

      // overflow
      apply_stimulus(4'b1000, 1'b0, 1'b1);
      step(8);
      apply_stimulus(4'b0000, 1'b0, 1'b1);
      step(8);
      check_output("lit_ovf_first", {3'b0, event_overflow}, 4'b0000);
      apply_stimulus(4'b1000, 1'b0, 1'b1);
      step(8);
      check_output("lit_ovf_second", {3'b0, event_overflow}, 4'b0001);
      apply_stimulus(4'b0000, 1'b0, 1'b1);
      step(8);
      read_port();
      check_output("lit_ovf_cleared", {3'b0, event_overflow}, 4'b0000);
      check_output("lit_ovf_sticky", pins_out, 4'b0000);

      // level mode, mode switch, mid-debounce reset
      apply_stimulus(4'b0010, 1'b0, 1'b0);
      step(8);
      check_output("lit_level_press", pins_out, 4'b0010);
      apply_stimulus(4'b0000, 1'b0, 1'b0);
      step(5);
      check_output("lit_level_edge5", pins_out, 4'b0010);
      step(1);
      check_output("lit_level_edge6", pins_out, 4'b0000);
      mode_sticky = 1'b1;
      #1 check_output("lit_mode_switch", pins_out, 4'b0010);
      apply_stimulus(4'b0100, 1'b0, 1'b1);
      step(3);
      reset = 1'b0;
      #1 check_output("lit_midreset_pins", pins_out, 4'b0000);
      check_output("lit_midreset_stable", stable_level, 4'b0000);
      step(1);
      reset = 1'b1;
      step(5);
      check_output("lit_rerun_edge5", stable_level, 4'b0000);
      step(1);
      check_output("lit_rerun_edge6", stable_level, 4'b0100);

      // random traffic with slow-changing buttons
      for (int n = 0; n < 800; n++) begin
         for (int b = 0; b < WIDTH; b++) begin
            if ($urandom_range(9) == 0) raw_buttons[b] = ~raw_buttons[b];
         end
         rd_strobe   = ($urandom_range(7) == 0);
         mode_sticky = $urandom_range(1) == 1;
         reset       = ($urandom_range(299) != 0);
         step(1);
      end
      reset = 1'b1;
      rd_strobe = 1'b0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
